// File: rtl/axi_r_responder.sv
// AXI read-channel responder: queues AR requests in order and replays each
// one as an INCR burst whose beat data is the beat address itself.
module axi_r_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  arvalid,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  output logic                  arready,
  output logic                  rvalid,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  input  logic                  rready,
  output logic                  done_valid,
  output logic [ID_WIDTH-1:0]   done_id
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SH = $clog2(DATA_WIDTH / 8);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
  } ar_req_t;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;

  ar_req_t               q_mem [DEPTH];
  ar_req_t               head;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  push, pop, beat_hs;
  r_state_t              state_q, state_d;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [ADDR_WIDTH-1:0] base_q, beat_addr;
  logic [7:0]            len_q, beat_q;

  // No full-bypass: a full queue refuses AR even if the head pops this cycle.
  assign arready = reset_n && (count != CW'(DEPTH));
  assign push    = arvalid && arready;
  assign pop     = (state_q == R_IDLE) && (count != '0);
  assign head    = q_mem[rd_ptr];
  assign beat_hs = rvalid && rready;

  // Beat address wraps at the top of the address space.
  assign beat_addr = base_q + (ADDR_WIDTH'(beat_q) << SH);

  // Queue storage; contents are don't-care until a push, so no reset.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{id: arid, addr: araddr, len: arlen};
  end

  // Queue pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // R-channel state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= R_IDLE;
    else          state_q <= state_d;
  end

  // Next state and R-channel outputs; data is gated to zero outside a burst.
  always_comb begin
    state_d = state_q;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rdata   = '0;
    rresp   = 2'b00;
    rid     = rid_q;
    case (state_q)
      R_IDLE: begin
        if (pop) state_d = R_BURST;
      end
      R_BURST: begin
        rvalid = 1'b1;
        rlast  = (beat_q == len_q);
        rdata  = DATA_WIDTH'(beat_addr);
        if (beat_hs && rlast) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Burst context: loaded on pop, beat advances on each non-final handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rid_q  <= '0;
      base_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
    end else if (pop) begin
      rid_q  <= head.id;
      base_q <= head.addr;
      len_q  <= head.len;
      beat_q <= '0;
    end else if (beat_hs && !rlast) begin
      beat_q <= beat_q + 8'd1;
    end
  end

  // Completion pulse, one cycle after the final beat handshakes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_valid <= 1'b0;
      done_id    <= '0;
    end else begin
      done_valid <= beat_hs && rlast;
      done_id    <= rid_q;
    end
  end

endmodule

// File: tb/tb_axi_r_responder.sv
// Scoreboard bench for axi_r_responder: stimulus pushes expected beats and
// completions; a negedge monitor pops and compares what the DUT presents.
module tb_axi_r_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arvalid;
  logic [3:0]  arid;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic        arready;
  logic        rvalid;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rready;
  logic        done_valid;
  logic [3:0]  done_id;

  axi_r_responder #(.ADDR_WIDTH(16), .ID_WIDTH(4), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .arvalid(arvalid), .arid(arid), .araddr(araddr), .arlen(arlen), .arready(arready),
    .rvalid(rvalid), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready),
    .done_valid(done_valid), .done_id(done_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t      exp_q[$];
  logic [3:0] done_q[$];
  int         err = 0;
  int         total = 0;
  int         hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one AR and hold it until accepted; expected beats are queued
  // once acceptance is certain (arready seen high before the edge).
  task automatic ar_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len);
    bit ok = 0;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin
      err++;
      $display("FAIL ar_accept id=%0d: arready stayed 0, required 1 within 200 cycles", id);
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        beat_t b;
        logic [15:0] a;
        a = addr + 16'(i * 4);
        b.id = id; b.data = {16'h0, a}; b.last = (i == int'(len));
        exp_q.push_back(b);
      end
      done_q.push_back(id);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // Run until every expected beat and completion has been seen.
  task automatic wait_drain(input bit toggle);
    bit ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (toggle) rready = ~rready;
      if (exp_q.size() == 0 && done_q.size() == 0) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin
      err++;
      $display("FAIL drain: %0d beats and %0d dones outstanding, required 0", exp_q.size(), done_q.size());
    end
    rready = 1'b1;
  endtask

  // Monitor: hold checks during stalls, beat and completion scoreboard.
  bit          mon_stall = 0;
  logic [3:0]  mon_id;
  logic [31:0] mon_data;
  logic        mon_last;
  logic [1:0]  mon_resp;
  beat_t       mon_e;
  logic [3:0]  mon_d;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_stall = 0;
    end else begin
      if (mon_stall) begin
        chk("hold_rvalid", 32'(rvalid), 32'd1);
        chk("hold_rid",    32'(rid),    32'(mon_id));
        chk("hold_rdata",  rdata,       mon_data);
        chk("hold_rlast",  32'(rlast),  32'(mon_last));
        chk("hold_rresp",  32'(rresp),  32'(mon_resp));
      end
      if (rvalid && rready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          err++; total++;
          $display("FAIL r_beat: unexpected beat rid=%0d rdata=%h, required none", rid, rdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("r_rid",   32'(rid),   32'(mon_e.id));
          chk("r_rdata", rdata,      mon_e.data);
          chk("r_rlast", 32'(rlast), 32'(mon_e.last));
          chk("r_rresp", 32'(rresp), 32'd0);
        end
      end
      mon_stall = rvalid && !rready;
      mon_id = rid; mon_data = rdata; mon_last = rlast; mon_resp = rresp;
      if (done_valid) begin
        if (done_q.size() == 0) begin
          err++; total++;
          $display("FAIL done: unexpected done_id=%0d, required none", done_id);
        end else begin
          mon_d = done_q.pop_front();
          chk("done_id", 32'(done_id), 32'(mon_d));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid",     32'(rvalid),     32'd0);
    chk("rst_rlast",      32'(rlast),      32'd0);
    chk("rst_rid",        32'(rid),        32'd0);
    chk("rst_rdata",      rdata,           32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_id",    32'(done_id),    32'd0);
    chk("rst_arready",    32'(arready),    32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_arready", 32'(arready), 32'd1);

    // Single beat, with request-to-first-beat latency of two clocks.
    @(posedge clk); #1;
    rready = 1'b1;
    ar_send(4'd3, 16'h0100, 8'd0);
    @(negedge clk);
    chk("lat_after_t0", 32'(rvalid), 32'd0);
    @(negedge clk);
    chk("lat_after_t1", 32'(rvalid), 32'd1);
    chk("lat_rid",      32'(rid),    32'd3);
    wait_drain(0);

    // Four-beat burst under toggling rready.
    ar_send(4'd5, 16'h0040, 8'd3);
    wait_drain(1);

    // Queue full. A stalled blocker burst occupies the engine so IDs 1..4
    // stay in the queue and fill it; ID 5 must then be refused.
    rready = 1'b0;
    ar_send(4'd10, 16'h0300, 8'd1);
    ar_send(4'd1, 16'h1000, 8'd0);
    ar_send(4'd2, 16'h2000, 8'd1);
    ar_send(4'd3, 16'h3000, 8'd0);
    ar_send(4'd4, 16'h4000, 8'd2);
    arvalid = 1'b1; arid = 4'd5; araddr = 16'h5000; arlen = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_arready", 32'(arready), 32'd0);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    ar_send(4'd5, 16'h5000, 8'd0);
    wait_drain(0);

    // Address wrap at the top of the 16-bit space.
    ar_send(4'd9, 16'hFFF8, 8'd3);
    wait_drain(0);

    // AR accepted on the same edge as the last beat of a running burst.
    ar_send(4'd11, 16'h0500, 8'd2);
    repeat (3) @(posedge clk);
    #1;
    ar_send(4'd12, 16'h0600, 8'd1);
    @(negedge clk);
    chk("gap_idle_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    chk("gap_next_rvalid", 32'(rvalid), 32'd1);
    chk("gap_next_rid",    32'(rid),    32'd12);
    wait_drain(0);

    // Reset after beat 2 of an 8-beat burst with two requests queued.
    rready = 1'b0;
    ar_send(4'd6, 16'h0200, 8'd7);
    ar_send(4'd7, 16'h0700, 8'd1);
    ar_send(4'd8, 16'h0800, 8'd1);
    rready = 1'b1;
    begin
      int base;
      bit ok;
      base = hs_cnt; ok = 0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        if (hs_cnt - base >= 3) begin ok = 1; break; end
      end
      chk("rst_mid_reached", 32'(ok), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    chk("rst_mid_rvalid",  32'(rvalid),     32'd0);
    chk("rst_mid_rlast",   32'(rlast),      32'd0);
    chk("rst_mid_done",    32'(done_valid), 32'd0);
    chk("rst_mid_arready", 32'(arready),    32'd0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_beat", 32'(rvalid), 32'd0);
    end
    chk("post_rst_arready2", 32'(arready), 32'd1);
    @(posedge clk); #1;
    ar_send(4'd2, 16'h0010, 8'd0);
    wait_drain(0);

    $display("Result: errors=%0d of %0d checks", err, total);
    $finish;
  end

endmodule
